// File: rtl/vga_pkg.sv
// Shared VGA types: display modes, colour constants and default active-area size.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_V_ACTIVE = 480;

  typedef enum logic [2:0] {
    SOLID_R = 3'd0,
    SOLID_G = 3'd1,
    SOLID_B = 3'd2,
    BARS    = 3'd3,
    CHECKER = 3'd4
  } mode_e;

  localparam logic [23:0] RED     = 24'hFF0000;
  localparam logic [23:0] GREEN   = 24'h00FF00;
  localparam logic [23:0] BLUE    = 24'h0000FF;
  localparam logic [23:0] WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BLACK   = 24'h000000;
  localparam logic [23:0] YELLOW  = 24'hFFFF00;
  localparam logic [23:0] CYAN    = 24'h00FFFF;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;

  // Next mode in the cycle, CHECKER (or any unused code) wraps to SOLID_R.
  function automatic mode_e mode_next(mode_e m);
    return (m >= CHECKER) ? SOLID_R : mode_e'(m + 3'd1);
  endfunction

  // Previous mode in the cycle, SOLID_R (or any unused code) wraps to CHECKER.
  function automatic mode_e mode_prev(mode_e m);
    return (m == SOLID_R || m > CHECKER) ? CHECKER : mode_e'(m - 3'd1);
  endfunction

  // Colour bar by index; anything past the last bar shows the last bar (black).
  function automatic logic [23:0] bar_color(int unsigned idx);
    case (idx)
      32'd0:   return WHITE;
      32'd1:   return YELLOW;
      32'd2:   return CYAN;
      32'd3:   return GREEN;
      32'd4:   return MAGENTA;
      32'd5:   return RED;
      32'd6:   return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises one raw key, debounces it and emits a one-cycle press pulse.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive mismatch cycles; flip the level on the last one.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_key;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;
  assign o_press = press_q;

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Key-driven test-pattern generator; mode changes land only on frame boundaries.
module vga_pattern_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BAR_WIDTH       = 80
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_key,
  input  logic        i_sending,
  input  logic        i_v_sync,
  output logic [23:0] o_color,
  output logic [2:0]  o_mode,
  output logic        o_mode_changed
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  logic [2:0]    key_press;
  logic [2:0]    key_level_unused;
  logic          vsync_q, sending_q;
  logic          frame_start, line_end;
  mode_e         pending_q, pending_d, pending_ok;
  mode_e         mode_q, mode_d;
  logic          changed_q, changed_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [23:0]   color_q, color_d;

  for (genvar i = 0; i < 3; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key   (i_key[i]),
      .o_level (key_level_unused[i]),
      .o_press (key_press[i])
    );
  end

  assign frame_start = vsync_q & ~i_v_sync;
  assign line_end    = sending_q & ~i_sending;

  // Pending mode takes one key event per cycle; displayed mode follows it at frame start.
  always_comb begin
    pending_ok = (pending_q > CHECKER) ? SOLID_R : pending_q;
    pending_d  = pending_ok;
    if (key_press[2])      pending_d = SOLID_R;
    else if (key_press[0]) pending_d = mode_next(pending_ok);
    else if (key_press[1]) pending_d = mode_prev(pending_ok);
    mode_d    = mode_q;
    changed_d = 1'b0;
    if (frame_start) begin
      mode_d    = pending_ok;
      changed_d = (pending_ok != mode_q);
    end
  end

  // Active-pixel position tracking from the sending flag.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_start) begin
      x_d = '0;
      y_d = '0;
    end else if (i_sending) begin
      if (x_q != X_MAX) x_d = x_q + XW'(1);
    end else if (line_end) begin
      x_d = '0;
      if (y_q != Y_MAX) y_d = y_q + YW'(1);
    end
  end

  // Pixel colour for the current position in the displayed mode.
  always_comb begin
    color_d = BLACK;
    if (i_sending) begin
      case (mode_q)
        SOLID_R: color_d = RED;
        SOLID_G: color_d = GREEN;
        SOLID_B: color_d = BLUE;
        BARS:    color_d = bar_color(32'(x_q) / BAR_WIDTH);
        CHECKER: color_d = (((32'(x_q) ^ 32'(y_q)) & 32'h20) != 32'd0) ? WHITE : BLACK;
        default: color_d = BLACK;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync_q   <= 1'b0;
      sending_q <= 1'b0;
      pending_q <= SOLID_R;
      mode_q    <= SOLID_R;
      changed_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
    end else begin
      vsync_q   <= i_v_sync;
      sending_q <= i_sending;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      changed_q <= changed_d;
      x_q       <= x_d;
      y_q       <= y_d;
      color_q   <= color_d;
    end
  end

  assign o_color        = color_q;
  assign o_mode         = mode_q;
  assign o_mode_changed = changed_q;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Bench for vga_pattern_scheduler: table vectors, directed sequences and random traffic vs a reference model.
module tb_vga_pattern_scheduler;

  localparam int DEB = 4;
  localparam int HA  = 640;
  localparam int VA  = 480;
  localparam int BW  = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  key = 3'b000;
  logic        sending = 1'b0;
  logic        v_sync = 1'b1;
  logic [23:0] color;
  logic [2:0]  mode;
  logic        changed;

  vga_pattern_scheduler #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .DEBOUNCE_CYCLES(DEB), .BAR_WIDTH(BW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_sending(sending), .i_v_sync(v_sync),
    .o_color(color), .o_mode(mode), .o_mode_changed(changed)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model state
  int          m_mode, m_pend, m_x, m_y, m_chg;
  logic [23:0] m_color;
  logic        m_vprev, m_sprev;
  logic [2:0]  m_press, m_level, kh0, kh1;
  int          m_run [3];
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] ref_pixel(int md, int x, int y);
    int idx;
    case (md)
      0: return 24'hFF0000;
      1: return 24'h00FF00;
      2: return 24'h0000FF;
      3: begin
        idx = x / BW;
        if (idx > 7) idx = 7;
        return bar_tab[idx];
      end
      4: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_x = 0; m_y = 0; m_chg = 0; m_color = '0;
    m_vprev = 1'b0; m_sprev = 1'b0; m_press = '0; m_level = '0; kh0 = '0; kh1 = '0;
    for (int k = 0; k < 3; k++) m_run[k] = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_step();
    logic       bnd;
    logic [2:0] ev;
    m_color = sending ? ref_pixel(m_mode, m_x, m_y) : 24'h000000;
    bnd = m_vprev && !v_sync;
    ev  = m_press;
    m_chg = 0;
    if (bnd) begin
      m_chg  = (m_pend != m_mode) ? 1 : 0;
      m_mode = m_pend;
    end
    if (ev[2])      m_pend = 0;
    else if (ev[0]) m_pend = (m_pend + 1) % 5;
    else if (ev[1]) m_pend = (m_pend + 4) % 5;
    if (bnd) begin
      m_x = 0; m_y = 0;
    end else if (sending) begin
      m_x = (m_x < HA - 1) ? m_x + 1 : HA - 1;
    end else if (m_sprev) begin
      m_x = 0;
      m_y = (m_y < VA - 1) ? m_y + 1 : VA - 1;
    end
    for (int k = 0; k < 3; k++) begin
      m_press[k] = 1'b0;
      if (kh1[k] != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_level[k] = kh1[k];
          m_press[k] = kh1[k];
          m_run[k]   = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    kh1 = kh0; kh0 = key; m_vprev = v_sync; m_sprev = sending;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("color", 32'(color), 32'(m_color));
    check("mode", 32'(mode), 32'(m_mode));
    check("changed", 32'(changed), 32'(m_chg));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic press_keys(input logic [2:0] mask, input int hold);
    key = mask;
    repeat (hold) step();
    key = 3'b000;
    repeat (DEB + 4) step();
  endtask

  task automatic frame_edge();
    v_sync = 1'b0; step();
    v_sync = 1'b1; step();
  endtask

  task automatic set_mode(input int target);
    for (int n = 0; n < 5 && m_pend != target; n++) press_keys(3'b001, 8);
  endtask

  task automatic probe(input int px, input int py, output logic [23:0] got);
    frame_edge();
    repeat (py) begin
      sending = 1'b1; step();
      sending = 1'b0; step();
    end
    sending = 1'b1;
    repeat (px + 1) step();
    got = color;
    sending = 1'b0;
    step();
  endtask

  typedef struct {
    int          md;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [23:0] got;
    int          hold_k, run_s;

    tbl.push_back('{3, 0,   0,   24'hFFFFFF});
    tbl.push_back('{3, 79,  0,   24'hFFFFFF});
    tbl.push_back('{3, 80,  0,   24'hFFFF00});
    tbl.push_back('{3, 160, 5,   24'h00FFFF});
    tbl.push_back('{3, 639, 0,   24'h000000});
    tbl.push_back('{3, 645, 0,   24'h000000});
    tbl.push_back('{4, 31,  0,   24'h000000});
    tbl.push_back('{4, 32,  0,   24'hFFFFFF});
    tbl.push_back('{4, 32,  32,  24'h000000});
    tbl.push_back('{4, 0,   32,  24'hFFFFFF});
    tbl.push_back('{4, 70,  40,  24'hFFFFFF});
    tbl.push_back('{4, 0,   485, 24'h000000});

    // Reset state
    model_reset();
    #12;
    check("rst_color", 32'(color), 32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_changed", 32'(changed), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Mode 0 after reset: red during active video, black outside
    idle(3);
    frame_edge();
    probe(5, 2, got);
    check("t1_red_active", 32'(got), 32'hFF0000);
    check("t1_black_idle", 32'(color), 32'h0);

    // Bouncing key gives no event
    key = 3'b001; step();
    key = 3'b000; step();
    key = 3'b001; step(); step();
    key = 3'b000;
    idle(DEB + 4);
    frame_edge();
    check("t2_bounce_mode", 32'(mode), 32'd0);

    // Held key gives one event, applied only at the frame boundary
    press_keys(3'b001, 6);
    check("t2_mode_before_edge", 32'(mode), 32'd0);
    v_sync = 1'b0; step();
    check("t2_mode_at_edge", 32'(mode), 32'd1);
    check("t2_changed_pulse", 32'(changed), 32'd1);
    v_sync = 1'b1; step();
    check("t2_changed_clear", 32'(changed), 32'd0);

    // Wrap in both directions
    press_keys(3'b100, 8); frame_edge();
    check("t3_key2_solid_r", 32'(mode), 32'd0);
    press_keys(3'b010, 8); frame_edge();
    check("t3_wrap_prev", 32'(mode), 32'd4);
    press_keys(3'b001, 8); frame_edge();
    check("t3_wrap_next", 32'(mode), 32'd0);

    // Simultaneous events and several events within one frame
    press_keys(3'b001, 8); press_keys(3'b001, 8); frame_edge();
    check("t4_mode2", 32'(mode), 32'd2);
    press_keys(3'b101, 8); frame_edge();
    check("t4_key2_wins", 32'(mode), 32'd0);
    press_keys(3'b001, 8); press_keys(3'b001, 8); press_keys(3'b001, 8); frame_edge();
    check("t4_three_presses", 32'(mode), 32'd3);

    // Table of pattern pixels
    for (int i = 0; i < tbl.size(); i++) begin
      set_mode(tbl[i].md);
      probe(tbl[i].x, tbl[i].y, got);
      check($sformatf("tbl%0d_md%0d_x%0d_y%0d", i, tbl[i].md, tbl[i].x, tbl[i].y),
            32'(got), 32'(tbl[i].exp));
    end

    // Frame boundary mid-line resets y before the next pixels
    frame_edge();
    repeat (32) begin
      sending = 1'b1; step();
      sending = 1'b0; step();
    end
    sending = 1'b1; step();
    check("t6_pre_boundary", 32'(color), 32'hFFFFFF);
    v_sync = 1'b0; step();
    v_sync = 1'b1; step();
    check("t6_post_boundary", 32'(color), 32'h000000);
    sending = 1'b0; step();

    // Random traffic against the model, with one asynchronous reset
    hold_k = 0;
    run_s  = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_k == 0) begin
        key    = 3'($urandom_range(0, 7));
        hold_k = int'($urandom_range(1, 12));
      end
      hold_k--;
      if (run_s == 0) begin
        sending = ~sending;
        run_s   = sending ? int'($urandom_range(1, 700)) : int'($urandom_range(1, 20));
      end
      run_s--;
      v_sync = ($urandom_range(0, 149) != 0);
      step();
      if (c == 2000) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_color", 32'(color), 32'h0);
        check("async_rst_mode", 32'(mode), 32'h0);
        check("async_rst_changed", 32'(changed), 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_pattern_scheduler.md
Name: vga_pattern_scheduler

Overview:
Sequences the 24-bit colour stream fed to the VGA controller's colour input. It debounces the three board keys into mode-change events and applies a new pattern only at a frame boundary, so no frame tears. It tracks the active pixel position from the controller's sending flag and vertical sync, and renders solid, colour-bar or checkerboard patterns. It sits between the key inputs and VGA controller in the top level, in the 25 MHz pixel clock domain.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
DEBOUNCE_CYCLES, 250000, stable-input cycles needed to accept a key change (10 ms at 25 MHz)
BAR_WIDTH, 80, width in pixels of each colour bar

Ports:
i_clk  input  1  pixel clock (25 MHz)
i_rst_n  input  1  reset
i_key  input  3  raw key levels, 1 = pressed, asynchronous to i_clk
i_sending  input  1  VGA controller active-video flag, 1 per active pixel cycle
i_v_sync  input  1  VGA controller vertical sync, active-low pulse
o_color  output  24  {R,G,B} pixel to VGA controller
o_mode  output  3  currently displayed mode
o_mode_changed  output  1  one-cycle pulse when o_mode changes

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset values: o_color=0, o_mode=SOLID_R(0), o_mode_changed=0, pending mode=SOLID_R, x=y=0, debounced key state=0, synchronisers=0.
- Keys: each key passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles in which the synchronised level differs from the current debounced level.
  - Any mismatch-free cycle clears the counter.
  - A press event is a 0->1 edge of the debounced level, one cycle wide.
- Modes, encoded 3 bits: SOLID_R=0, SOLID_G=1, SOLID_B=2, BARS=3, CHECKER=4. Codes 5-7 are unused; if the pending mode ever holds one, it is forced to SOLID_R.
- Pending mode update, one event applied per cycle, priority key2 > key0 > key1:
  - key0: pending = next mode, CHECKER wraps to SOLID_R.
  - key1: pending = previous mode, SOLID_R wraps to CHECKER.
  - key2: pending = SOLID_R.
  - Multiple events in one cycle: only the highest priority is applied; the others are dropped.
- Frame boundary is a registered falling edge of i_v_sync.
  - On that cycle, o_mode <= pending.
  - o_mode_changed=1 on the following cycle only if the value differed.
  - An event in the same cycle as the boundary updates pending only; it takes effect at the next boundary.
- Position counters:
  - x increments on each i_sending=1 cycle, saturating at H_ACTIVE-1.
  - On the falling edge of i_sending, x<=0 and y increments, saturating at V_ACTIVE-1.
  - The frame boundary sets y<=0 and x<=0.
  - The first i_sending cycle of a line is pixel x=0.
- Colour, registered, latency 1: o_color at cycle t+1 is the pixel whose x,y were current at cycle t when i_sending=1. If i_sending=0 at cycle t, o_color=0 at t+1.
  - SOLID_R={FF,00,00}; SOLID_G={00,FF,00}; SOLID_B={00,00,FF}.
  - BARS: index = x/BAR_WIDTH, clamped to 7. Order: white, yellow, cyan, green, magenta, red, blue, black.
  - CHECKER: white when x[5]^y[5] is 1, else black (32x32 squares).
  - Colour uses the displayed mode o_mode, never pending.
- Reset mid-frame returns every output to its reset value immediately. Counting resumes from x=y=0; rows stay offset until the next frame boundary. This is acceptable.

Decomposition:
- Package vga_pkg holds:
  - mode enum (mode_e, 3 bits);
  - 24-bit colour constants: RED, GREEN, BLUE, WHITE, BLACK, YELLOW, CYAN, MAGENTA;
  - default H_ACTIVE/V_ACTIVE localparams, shared with the VGA controller.
- Sub-module key_debouncer: synchroniser, counter and edge detect, parameter DEBOUNCE_CYCLES. It is instantiated three times; outputs are level and press pulse.

Test Plan:
1. Reset: i_rst_n low, then release with no keys and vsync toggling -> o_mode=0. During active video o_color=FF0000; outside it o_color=0. o_mode_changed stays 0.
2. Debounce (DEBOUNCE_CYCLES=4):
   - key0 bouncing 1,0,1,1 -> no event.
   - key0 held 6 cycles -> exactly one event. o_mode stays 0 until the next i_v_sync fall, then becomes 1 with o_mode_changed pulsed one cycle.
3. Wrap: key1 press from SOLID_R, then vsync fall -> o_mode=4. key0 press, then vsync fall -> o_mode=0.
4. Simultaneous: key0 and key2 events in the same cycle from mode 2 -> after the boundary o_mode=0. Then key0 ×3 within one frame -> o_mode=3 at the next boundary.
5. BARS at H_ACTIVE=640, BAR_WIDTH=80 -> o_color for x=0 is FFFFFF, x=79 is FFFFFF, x=80 is FFFF00, x=639 is 000000. Each appears one cycle after the corresponding i_sending cycle.
6. CHECKER -> (x=31,y=0) is 000000, (x=32,y=0) is FFFFFF, (x=32,y=32) is 000000. A frame boundary mid-line resets y to 0 before the next line.
